// File: rtl/modexp_sequencer.sv
// Job sequencer for an external modular-exponentiation unit: accepts a job,
// screens it, loads the unit, waits for completion under a watchdog, holds the result.
module modexp_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = DATA_WIDTH + 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] base,
  input  logic [DATA_WIDTH-1:0] expo,
  input  logic [DATA_WIDTH-1:0] modulant,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] exp_a,
  output logic [DATA_WIDTH-1:0] exp_b,
  output logic [DATA_WIDTH-1:0] exp_mod,
  output logic                  exp_set,
  input  logic [DATA_WIDTH-1:0] exp_out,
  input  logic                  exp_finished,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SET, WAIT, HOLD} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      count, count_nxt;
  logic [DATA_WIDTH-1:0] a_nxt, b_nxt, mod_nxt, result_nxt;
  logic                  error_nxt;
  logic                  bad_job;

  // Even (or zero) moduli and unreduced bases are outside what the unit supports.
  assign bad_job = ~modulant[0] | (base >= modulant);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= '0;
      exp_a   <= '0;
      exp_b   <= '0;
      exp_mod <= '0;
      result  <= '0;
      error   <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      exp_a   <= a_nxt;
      exp_b   <= b_nxt;
      exp_mod <= mod_nxt;
      result  <= result_nxt;
      error   <= error_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    a_nxt      = exp_a;
    b_nxt      = exp_b;
    mod_nxt    = exp_mod;
    result_nxt = result;
    error_nxt  = error;
    in_ready   = 1'b0;
    exp_set    = 1'b0;
    out_valid  = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_nxt   = base;
          b_nxt   = expo;
          mod_nxt = modulant;
          if (bad_job) begin
            result_nxt = '0;
            error_nxt  = 1'b1;
            state_nxt  = HOLD;
          end else begin
            state_nxt = SET;
          end
        end
      end

      // exp_finished is not looked at here: it may still be high from the last job.
      SET: begin
        exp_set   = 1'b1;
        count_nxt = '0;
        state_nxt = WAIT;
      end

      // Completion is tested before the watchdog so a finish on the last cycle wins.
      WAIT: begin
        if (exp_finished) begin
          result_nxt = exp_out;
          error_nxt  = 1'b0;
          state_nxt  = HOLD;
        end else begin
          count_nxt = count + 1'b1;
          if (count == CNT_W'(TIMEOUT - 1)) begin
            result_nxt = '0;
            error_nxt  = 1'b1;
            state_nxt  = HOLD;
          end
        end
      end

      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/modexp_sequencer.md
MODEXP_SEQUENCER -- requirements
Module: modexp_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the operand width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default DATA_WIDTH+4, giving the maximum WAIT cycles before a watchdog error.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset: clock  in  1  rising-edge clock; reset_n  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have these job inputs: in_valid  in  1  job offered; base  in  DATA_WIDTH  base operand; expo  in  DATA_WIDTH  exponent; modulant  in  DATA_WIDTH  modulus.
REQ-005 The block SHALL have in_ready  out  1  job accepted when high with in_valid.
REQ-006 The block SHALL drive the exponentiation unit through: exp_a  out  DATA_WIDTH  latched base; exp_b  out  DATA_WIDTH  latched exponent; exp_mod  out  DATA_WIDTH  latched modulant; exp_set  out  1  load pulse.
REQ-007 The block SHALL receive from the exponentiation unit: exp_out  in  DATA_WIDTH  unit result; exp_finished  in  1  unit done level.
REQ-008 The block SHALL have these result outputs: out_valid  out  1  result held; out_ready  in  1  consumer accepts; result  out  DATA_WIDTH  result value; error  out  1  job rejected or timed out.

Function
REQ-009 The FSM SHALL have exactly the states IDLE, SET, WAIT and HOLD.
REQ-010 In IDLE, in_ready SHALL be 1; in every other state it SHALL be 0.
REQ-011 On a rising edge in IDLE with in_valid=1, the block SHALL latch base, expo and modulant into exp_a, exp_b and exp_mod.
REQ-012 If the accepted modulant is even (including 0), or base >= modulant, the block SHALL go IDLE->HOLD with error=1 and result=0, and SHALL NOT pulse exp_set.
REQ-013 Otherwise the block SHALL go IDLE->SET.
REQ-014 In SET, exp_set SHALL be 1 for exactly one cycle and the next state SHALL be WAIT; exp_finished SHALL be ignored in SET because it may be stale from the previous job.
REQ-015 exp_a, exp_b and exp_mod SHALL stay constant from acceptance until the block returns to IDLE.
REQ-016 In WAIT, a watchdog counter SHALL start at 0 on entry and increment each cycle while exp_finished=0.
REQ-017 In WAIT, exp_finished=1 SHALL capture exp_out into result with error=0 and move to HOLD on that edge.
REQ-018 In WAIT, if the counter reaches TIMEOUT with exp_finished still 0, the block SHALL move to HOLD with error=1 and result=0.
REQ-019 If exp_finished and the timeout occur in the same cycle, exp_finished SHALL win.
REQ-020 In HOLD, out_valid SHALL be 1, and result and error SHALL be stable until the handshake.
REQ-021 A HOLD cycle with out_ready=1 SHALL complete the handshake and return to IDLE.
REQ-022 A job SHALL NOT be accepted in the handshake cycle; the earliest next acceptance SHALL be the following cycle.
REQ-023 out_ready SHALL be ignored outside HOLD.
REQ-024 out_valid SHALL NOT fall in HOLD without a handshake.
REQ-025 Latency SHALL be: acceptance edge, 1 SET cycle, N WAIT cycles until exp_finished, then out_valid on the next cycle.
REQ-026 The watchdog counter SHALL be wide enough to hold TIMEOUT without wrap-around.

Reset
REQ-027 While reset_n=0, regardless of state, the block SHALL force IDLE, in_ready=1, exp_set=0, out_valid=0, error=0, result=0, exp_a=0, exp_b=0, exp_mod=0 and counter=0.
REQ-028 Reset assertion mid-job SHALL abandon the job without an output handshake.
REQ-029 The first acceptance SHALL be possible on the first rising edge after reset_n rises.

Verification
REQ-030 Nominal job: base=5, expo=3, modulant=13, stub returns exp_out=8 with exp_finished two cycles after exp_set -> exactly one exp_set pulse, then out_valid=1, result=8, error=0.
REQ-031 Even modulus: modulant=12 -> no exp_set pulse, and HOLD is entered the next cycle with error=1, result=0.
REQ-032 Stale finished: exp_finished held at 1 through SET -> no capture in SET; capture occurs in the first WAIT cycle.
REQ-033 Timeout: stub never finishes -> out_valid rises with error=1 after TIMEOUT (12) WAIT cycles.
REQ-034 Backpressure: out_ready=0 for 5 cycles in HOLD with in_valid=1 -> result stable, in_ready=0, no second acceptance; out_ready=1 -> IDLE, and the new job is accepted on the next edge.
REQ-035 Mid-WAIT reset: reset_n=0 for 1 cycle during WAIT -> all outputs at reset values, and no out_valid afterwards.
